// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package ssd_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StCommit = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 13-bit binary to four BCD digits.
// Starts when the input differs from the last converted value; commits atomically.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic        busy,
  output logic [15:0] bcd
);

  conv_state_e state_q, state_d;
  logic [28:0] shift_q, shift_d, adj;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [12:0] held_q, held_d;
  logic        busy_q, busy_d;
  logic [15:0] bcd_q, bcd_d;

  // Add-3 correction on every BCD nibble that will overflow when doubled.
  always_comb begin
    adj = shift_q;
    for (int i = 0; i < 4; i++) begin
      if (shift_q[13+4*i +: 4] >= 4'd5) begin
        adj[13+4*i +: 4] = shift_q[13+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    held_d    = held_q;
    busy_d    = busy_q;
    bcd_d     = bcd_q;
    case (state_q)
      StIdle: begin
        if (value != held_q) begin
          state_d   = StShift;
          held_d    = value;
          shift_d   = {16'b0, value};
          bit_cnt_d = 4'd0;
          busy_d    = 1'b1;
        end
      end
      StShift: begin
        shift_d   = {adj[27:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd12) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        bcd_d   = shift_q[28:13];
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      held_q    <= '0;
      busy_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      held_q    <= held_d;
      busy_q    <= busy_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_display_driver.sv
// Four-digit common-anode seven-segment driver for the CPU's 13-bit debug value.
// Converts to BCD in the background and multiplexes committed digits onto the display.
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic        busy,
  output logic [15:0] bcd
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] refresh_cnt_q;
  logic [1:0]      digit_sel_q;
  logic [3:0]      anode_q, anode_d;
  logic [6:0]      cathode_q, cathode_d;
  logic [3:0]      nib;
  logic            lz_blank;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .busy  (busy),
    .bcd   (bcd)
  );

  // A digit above the lowest is a leading zero when it and every higher nibble are zero.
  always_comb begin
    nib = bcd[{digit_sel_q, 2'b00} +: 4];
    case (digit_sel_q)
      2'd1:    lz_blank = (bcd[15:4] == 12'd0);
      2'd2:    lz_blank = (bcd[15:8] == 8'd0);
      2'd3:    lz_blank = (bcd[15:12] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
    anode_d   = ~(4'b0001 << digit_sel_q);
    cathode_d = (BLANK_LZ && lz_blank) ? SEG_BLANK : seg7(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      digit_sel_q   <= 2'd0;
      anode_q       <= 4'b1111;
      cathode_q     <= SEG_BLANK;
    end else begin
      if (refresh_cnt_q == CntMax) begin
        refresh_cnt_q <= '0;
        digit_sel_q   <= digit_sel_q + 2'd1;
      end else begin
        refresh_cnt_q <= refresh_cnt_q + 1'b1;
      end
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule
